and_scoreboard: RTL and testbench



---
 rtl/and_sb_pkg.sv | 24 ++
 rtl/sb_fifo.sv | 62 ++++++
 rtl/and_scoreboard.sv | 150 +++++++++++++++
 tb/tb_and_scoreboard.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/and_sb_pkg.sv
// Shared definitions for the AND-gate response scoreboard: FSM encoding and helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package and_sb_pkg;

    // Scoreboard FSM encoding, kept as plain constants for older tool flows
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Number of queue entries for a given address width
    function automatic int depth_of(input int log2);
        return 1 << log2;
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32)
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Synchronous show-ahead FIFO holding expected results: head is visible on dout while not empty.
// Latency: a push is visible on dout the cycle after it is written; pop takes effect on the clock edge.
// Backpressure: push on full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module sb_fifo
    import and_sb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = depth_of(DEPTH_LOG2);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_pop;
    logic                do_push;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // A write on full is legal when the head leaves in the same edge (slot is reused)
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Storage array; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
        end
    end

    // Pointer update; flush empties the queue for a new run
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/and_scoreboard.sv
// In-order response scoreboard for an AND-gate DUT: queues a&b per operand pair and checks out_c.
// Latency: counters and flags update on the edge that samples out_vld/in_vld; readable one cycle later.
// Backpressure: none exerted; pairs arriving on a full queue are dropped and flagged as overflow.
module and_scoreboard
    import and_sb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_checks,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             out_vld,
    input  logic [WIDTH-1:0] out_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             overflow,
    output logic             timeout,
    output logic             first_err_vld,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_c
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] n_target;
    logic [CNT_W-1:0] push_cnt;
    logic [TO_W-1:0]  idle_cnt;

    logic             start_ok;
    logic             active;
    logic             push_en;
    logic             pop_en;
    logic             unexp;
    logic             mismatch;
    logic             err_evt;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;

    // A new run may only begin from a quiescent state
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign active   = (state == ST_RUN) || (state == ST_DRAIN);

    // Push/pop qualification; a pop on empty is never bypassed from a same-cycle push
    assign push_en   = (state == ST_RUN) && in_vld;
    assign pop_en    = active && out_vld && !fifo_empty;
    assign unexp     = active && out_vld && fifo_empty;
    assign fifo_push = push_en;
    assign mismatch  = pop_en && (fifo_head != out_c);
    assign err_evt   = mismatch || unexp;

    sb_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start_ok),
        .push  (fifo_push),
        .din   (in_a & in_b),
        .pop   (pop_en),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Run control: sequencing through RUN/DRAIN, push accounting and drain timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            n_target <= '0;
            push_cnt <= '0;
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (start_ok) begin
            n_target <= n_checks;
            push_cnt <= '0;
            idle_cnt <= '0;
            timeout  <= 1'b0;
            state    <= (n_checks == '0) ? ST_DONE : ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    // Dropped pairs still count so the run always terminates
                    if (push_en) begin
                        push_cnt <= push_cnt + 1'b1;
                        if ((push_cnt + 1'b1) == n_target) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    idle_cnt <= out_vld ? '0 : (idle_cnt + 1'b1);
                    if (fifo_empty) begin
                        state <= ST_DONE;
                    end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                        state   <= ST_DONE;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result checking: compare counts, saturating error count, overflow and first-failure capture
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            chk_cnt       <= '0;
            err_cnt       <= '0;
            overflow      <= 1'b0;
            first_err_vld <= 1'b0;
            first_err_exp <= '0;
            first_err_c   <= '0;
        end else begin
            if (pop_en) begin
                chk_cnt <= chk_cnt + 1'b1;
            end
            if (push_en && fifo_full && !pop_en) begin
                overflow <= 1'b1;
            end
            if (err_evt) begin
                err_cnt <= CNT_W'(sat_inc(32'(err_cnt), CNT_W));
                if (!first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_exp <= unexp ? '0 : fifo_head;
                    first_err_c   <= out_c;
                end
            end
        end
    end

    assign busy = active;
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == '0) && !overflow && !timeout;

endmodule

// File: tb/tb_and_scoreboard.sv
// Self-checking bench for and_scoreboard: table-driven scenarios, a reset sequence and random runs.
// Latency: emulated AND-gate DUT with configurable fixed latency driving out_vld/out_c.
// Backpressure: none; stimulus pacing is a fixed issue gap per run.
module tb_and_scoreboard;

    localparam int WIDTH      = 8;
    localparam int DEPTH_LOG2 = 4;
    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 1024;
    localparam int DEPTH      = 16;
    localparam int RUN_LIMIT  = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] n_checks;
    logic             in_vld;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_vld;
    logic [WIDTH-1:0] out_c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             overflow;
    logic             timeout;
    logic             first_err_vld;
    logic [WIDTH-1:0] first_err_exp;
    logic [WIDTH-1:0] first_err_c;

    always #5 clk = ~clk;

    and_scoreboard #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .n_checks      (n_checks),
        .in_vld        (in_vld),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_vld       (out_vld),
        .out_c         (out_c),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .chk_cnt       (chk_cnt),
        .err_cnt       (err_cnt),
        .overflow      (overflow),
        .timeout       (timeout),
        .first_err_vld (first_err_vld),
        .first_err_exp (first_err_exp),
        .first_err_c   (first_err_c)
    );

    typedef struct {
        bit         done;
        bit         busy;
        bit         pass;
        bit         ovf;
        bit         to;
        bit         fev;
        int         chk;
        int         err;
        logic [7:0] fexp;
        logic [7:0] fc;
    } exp_t;

    typedef struct {
        int         n;
        int         lat;
        int         gap;
        int         bad_idx;   // result index to corrupt, -1 for none
        logic [7:0] bad_mask;  // xor applied to the corrupted result
        int         drop;      // number of trailing results the DUT never returns
        bit         spur;      // out_vld pulse of 7E before any push
        bit         rnd;       // random operand pairs
        exp_t       e;
    } vec_t;

    int n_vec    = 0;
    int n_miscmp = 0;

    logic [7:0] fix_a [4];
    logic [7:0] fix_b [4];

    // Reference model state: an ordered queue of expected results plus run bookkeeping
    int         m_phase;   // 0 idle, 1 accepting pairs, 2 draining, 3 finished
    logic [7:0] m_q[$];
    int         m_n, m_pushes, m_idle, m_chk, m_err;
    bit         m_ovf, m_to, m_fev;
    logic [7:0] m_fexp, m_fc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    task automatic m_start(input int n);
        m_q.delete();
        m_n = n; m_pushes = 0; m_idle = 0; m_chk = 0; m_err = 0;
        m_ovf = 0; m_to = 0; m_fev = 0; m_fexp = 0; m_fc = 0;
        m_phase = (n == 0) ? 3 : 1;
    endtask

    task automatic m_note_err(input logic [7:0] e, input logic [7:0] c);
        if (m_err < 65535) m_err++;
        if (!m_fev) begin
            m_fev = 1; m_fexp = e; m_fc = c;
        end
    endtask

    // One clock of scoreboard behaviour given this cycle's inputs
    task automatic m_step(input bit iv, input logic [7:0] a, input logic [7:0] b,
                          input bit ov, input logic [7:0] c);
        int         sz;
        int         nxt;
        bit         took;
        logic [7:0] head;
        sz   = m_q.size();
        nxt  = m_phase;
        took = 0;
        if ((m_phase == 1 || m_phase == 2) && ov) begin
            if (sz > 0) begin
                head = m_q.pop_front();
                took = 1;
                m_chk++;
                if (head != c) m_note_err(head, c);
            end else begin
                m_note_err(8'h00, c);
            end
        end
        if (m_phase == 1 && iv) begin
            if (sz < DEPTH || took) m_q.push_back(a & b);
            else m_ovf = 1;
            m_pushes++;
            if (m_pushes == m_n) nxt = 2;
        end
        if (m_phase == 2) begin
            if (sz == 0) nxt = 3;
            else if (m_idle == TIMEOUT - 1) begin nxt = 3; m_to = 1; end
            m_idle = ov ? 0 : m_idle + 1;
        end
        m_phase = nxt;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.done = (m_phase == 3);
        e.busy = (m_phase == 1 || m_phase == 2);
        e.pass = e.done && (m_err == 0) && !m_ovf && !m_to;
        e.ovf = m_ovf; e.to = m_to; e.fev = m_fev;
        e.chk = m_chk; e.err = m_err; e.fexp = m_fexp; e.fc = m_fc;
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e);
        check({tag, ".done"},     32'(done),          32'(e.done));
        check({tag, ".busy"},     32'(busy),          32'(e.busy));
        check({tag, ".pass"},     32'(pass),          32'(e.pass));
        check({tag, ".chk_cnt"},  32'(chk_cnt),       32'(e.chk));
        check({tag, ".err_cnt"},  32'(err_cnt),       32'(e.err));
        check({tag, ".overflow"}, 32'(overflow),      32'(e.ovf));
        check({tag, ".timeout"},  32'(timeout),       32'(e.to));
        check({tag, ".fe_vld"},   32'(first_err_vld), 32'(e.fev));
        check({tag, ".fe_exp"},   32'(first_err_exp), 32'(e.fexp));
        check({tag, ".fe_c"},     32'(first_err_c),   32'(e.fc));
    endtask

    // Drive one complete run through the emulated DUT, stepping the model alongside
    task automatic run(input string tag, input vec_t v);
        int         sched_t[$];
        logic [7:0] sched_v[$];
        int         issued;
        bit         finished;
        bit         iv, ov;
        logic [7:0] a, b, c, r;
        issued   = 0;
        finished = 0;
        @(negedge clk);
        start = 1'b1; n_checks = CNT_W'(v.n);
        m_start(v.n);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < RUN_LIMIT; cyc++) begin
            if (m_phase == 3 && sched_t.size() == 0) begin
                finished = 1;
                break;
            end
            iv = (issued < v.n) && (cyc >= 2) && (((cyc - 2) % v.gap) == 0);
            a = 8'h00; b = 8'h00;
            if (iv) begin
                if (v.rnd) begin
                    a = 8'($urandom); b = 8'($urandom);
                end else if (issued < 4) begin
                    a = fix_a[issued]; b = fix_b[issued];
                end else begin
                    a = 8'(issued); b = 8'hFF;
                end
                if (issued < v.n - v.drop) begin
                    r = a & b;
                    if (issued == v.bad_idx) r = r ^ v.bad_mask;
                    sched_t.push_back(cyc + v.lat);
                    sched_v.push_back(r);
                end
                issued++;
            end
            ov = 0; c = 8'h00;
            if (v.spur && cyc == 0) begin
                ov = 1; c = 8'h7E;
            end else if (sched_t.size() > 0 && sched_t[0] == cyc) begin
                ov = 1; c = sched_v.pop_front();
                void'(sched_t.pop_front());
            end
            in_vld = iv; in_a = a; in_b = b; out_vld = ov; out_c = c;
            m_step(iv, a, b, ov, c);
            @(negedge clk);
        end
        in_vld = 1'b0; out_vld = 1'b0;
        check({tag, ".bounded"}, 32'(finished), 32'd1);
    endtask

    function automatic vec_t mk(input int n, input int lat, input int gap, input int bad_idx,
                                input logic [7:0] bad_mask, input int drop, input bit spur,
                                input bit p, input bit ovf, input bit to, input bit fev,
                                input int chk, input int err, input logic [7:0] fexp,
                                input logic [7:0] fc);
        vec_t v;
        v.n = n; v.lat = lat; v.gap = gap; v.bad_idx = bad_idx; v.bad_mask = bad_mask;
        v.drop = drop; v.spur = spur; v.rnd = 0;
        v.e.done = 1; v.e.busy = 0; v.e.pass = p; v.e.ovf = ovf; v.e.to = to; v.e.fev = fev;
        v.e.chk = chk; v.e.err = err; v.e.fexp = fexp; v.e.fc = fc;
        return v;
    endfunction

    vec_t tbl [7];

    initial begin
        vec_t rv;
        exp_t z;
        fix_a[0] = 8'hFF; fix_b[0] = 8'h0F;
        fix_a[1] = 8'hAA; fix_b[1] = 8'h55;
        fix_a[2] = 8'h00; fix_b[2] = 8'hFF;
        fix_a[3] = 8'h3C; fix_b[3] = 8'h3C;

        //              n   lat gap bad mask  drop spur pass ovf to fev chk err fexp   fc
        tbl[0] = mk(4,  1,  1,  -1, 8'h00, 0, 0,   1,   0,  0, 0,  4,  0, 8'h00, 8'h00);
        tbl[1] = mk(4,  1,  1,   2, 8'h01, 0, 0,   0,   0,  0, 1,  4,  1, 8'h00, 8'h01);
        tbl[2] = mk(20, 20, 1,  -1, 8'h00, 0, 0,   0,   1,  0, 1, 16,  1, 8'h00, 8'h10);
        tbl[3] = mk(20, 20, 2,  -1, 8'h00, 0, 0,   1,   0,  0, 0, 20,  0, 8'h00, 8'h00);
        tbl[4] = mk(4,  1,  1,  -1, 8'h00, 0, 1,   0,   0,  0, 1,  4,  1, 8'h00, 8'h7E);
        tbl[5] = mk(3,  1,  1,  -1, 8'h00, 1, 0,   0,   0,  1, 0,  2,  0, 8'h00, 8'h00);
        tbl[6] = mk(0,  1,  1,  -1, 8'h00, 0, 0,   1,   0,  0, 0,  0,  0, 8'h00, 8'h00);

        rst = 1'b1; start = 1'b0; n_checks = '0;
        in_vld = 1'b0; in_a = '0; in_b = '0; out_vld = 1'b0; out_c = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        z.done = 0; z.busy = 0; z.pass = 0; z.ovf = 0; z.to = 0; z.fev = 0;
        z.chk = 0; z.err = 0; z.fexp = 0; z.fc = 0;
        compare("reset", z);

        for (int i = 0; i < 7; i++) begin
            run($sformatf("tbl%0d", i), tbl[i]);
            compare($sformatf("tbl%0d", i), tbl[i].e);
        end

        // Spurious output mid-run, then a one-cycle reset wipes the partial run
        @(negedge clk);
        start = 1'b1; n_checks = 16'd5;
        @(negedge clk);
        start = 1'b0; out_vld = 1'b1; out_c = 8'h7E;
        @(negedge clk);
        out_vld = 1'b0; in_vld = 1'b1; in_a = 8'h01; in_b = 8'h01;
        check("spur.chk_cnt", 32'(chk_cnt), 32'd0);
        check("spur.err_cnt", 32'(err_cnt), 32'd1);
        check("spur.fe_c",    32'(first_err_c), 32'h7E);
        check("spur.busy",    32'(busy), 32'd1);
        @(negedge clk);
        in_vld = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compare("midrst", z);
        start = 1'b1; n_checks = 16'd1;
        @(negedge clk);
        start = 1'b0; in_vld = 1'b1; in_a = 8'h0F; in_b = 8'hF3;
        @(negedge clk);
        in_vld = 1'b0; out_vld = 1'b1; out_c = 8'h03;
        @(negedge clk);
        out_vld = 1'b0;
        for (int k = 0; k < 20 && !done; k++) @(negedge clk);
        z.done = 1; z.pass = 1; z.chk = 1;
        compare("after_rst", z);

        // Random runs checked against the queue model
        for (int i = 0; i < 10; i++) begin
            rv.n        = $urandom_range(1, 40);
            rv.lat      = $urandom_range(1, 24);
            rv.gap      = $urandom_range(1, 3);
            rv.bad_idx  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rv.n - 1)) : -1;
            rv.bad_mask = 8'($urandom_range(1, 255));
            rv.drop     = 0;
            rv.spur     = 1'($urandom_range(0, 3) == 0);
            rv.rnd      = 1;
            run($sformatf("rnd%0d", i), rv);
            compare($sformatf("rnd%0d", i), model_exp());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
